// File: rtl/pc_reg_if.sv
// pc_reg_if: bundle of the fetch-stage control and ROM-facing signals.
//
// Signals:
//   stall[5:0]               ctrl -> pc_reg   pipeline stall vector (bit 0 = fetch stall)
//   flush                    ctrl -> pc_reg   exception/ERET flush
//   new_pc[31:0]             ctrl -> pc_reg   flush target address
//   branch_flag_i            ID   -> pc_reg   branch/jump taken
//   branch_target_address_i  ID   -> pc_reg   branch target
//   pc[31:0]                 pc_reg -> ROM    fetch address
//   ce                       pc_reg -> ROM    fetch enable
//   branch_pending_o         pc_reg -> ctrl   redirect latched, waiting for stall release
//   misalign_o               pc_reg -> ctrl   only with PC_ALIGN_CHECK_EN defined
//
// Modports: master drives the control inputs and observes the outputs; slave is pc_reg.
// Optional feature macro: PC_ALIGN_CHECK_EN.

interface pc_reg_if;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] pc;
    logic        ce;
    logic        branch_pending_o;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_o;

    modport master (
        output stall, flush, new_pc, branch_flag_i, branch_target_address_i,
        input  pc, ce, branch_pending_o, misalign_o
    );

    modport slave (
        input  stall, flush, new_pc, branch_flag_i, branch_target_address_i,
        output pc, ce, branch_pending_o, misalign_o
    );
`else
    modport master (
        output stall, flush, new_pc, branch_flag_i, branch_target_address_i,
        input  pc, ce, branch_pending_o
    );

    modport slave (
        input  stall, flush, new_pc, branch_flag_i, branch_target_address_i,
        output pc, ce, branch_pending_o
    );
`endif
endinterface

// File: rtl/pc_reg.sv
// pc_reg: program counter stage feeding the instruction ROM.
//
// Produces the registered fetch address (pc) and chip enable (ce). Handles fetch stall,
// branch redirect and exception flush. A branch resolved while fetch is stalled is kept in a
// one-entry pending-redirect buffer and applied on the first unstalled cycle.
// Priority in RUN: flush > stall[0] > branch > pending > sequential increment.
//
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   synchronous active-high reset
//   bus   pc_reg_if.slave: stall/flush/new_pc/branch inputs, pc/ce/branch_pending_o outputs
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   Defined: redirect targets are loaded with bits [1:0] cleared and misalign_o pulses for
//   the cycle the corrected pc is presented. Undefined: targets are loaded unmodified.

module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input logic     clk,
    input logic     rst,
    pc_reg_if.slave bus
);

    typedef enum logic [0:0] {
        StOff,
        StRun
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    // Redirect request resolved this cycle (flush, live branch or pending entry).
    logic        load_en;
    logic [31:0] load_target;

    // Only the fetch stall bit matters to this stage.
    logic        unused_stall;
    assign unused_stall = ^bus.stall[5:1];

    function automatic logic [31:0] load_addr(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return {a[31:2], 2'b00};
`else
        return a;
`endif
    endfunction

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        load_en       = 1'b0;
        load_target   = 32'h0000_0000;

        unique case (state_q)
            // First cycle out of reset: enable fetch at RESET_PC, no increment.
            StOff: state_d = StRun;

            StRun: begin
                if (bus.flush) begin
                    load_en      = 1'b1;
                    load_target  = bus.new_pc;
                    pend_valid_d = 1'b0;
                end else if (bus.stall[0]) begin
                    // Newest branch wins if several resolve during one stall.
                    if (bus.branch_flag_i) begin
                        pend_target_d = bus.branch_target_address_i;
                        pend_valid_d  = 1'b1;
                    end
                end else if (bus.branch_flag_i) begin
                    // A live branch supersedes a stale pending entry.
                    load_en      = 1'b1;
                    load_target  = bus.branch_target_address_i;
                    pend_valid_d = 1'b0;
                end else if (pend_valid_q) begin
                    load_en      = 1'b1;
                    load_target  = pend_target_q;
                    pend_valid_d = 1'b0;
                end else begin
                    pc_d = pc_q + 32'(PC_STEP);
                end

                if (load_en) begin
                    pc_d = load_addr(load_target);
                end
            end

            default: state_d = StOff;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign misalign_d = load_en && (load_target[1:0] != 2'b00);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StOff;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    assign bus.pc               = pc_q;
    assign bus.ce               = (state_q == StRun);
    assign bus.branch_pending_o = pend_valid_q;
`ifdef PC_ALIGN_CHECK_EN
    assign bus.misalign_o       = misalign_q;
`endif

endmodule

// File: tb/tb_pc_reg.sv
// tb_pc_reg: self-checking bench for pc_reg. Each step drives one cycle of inputs, pushes the
// expected post-edge outputs onto a scoreboard queue, and pops/compares them after the edge.

module tb_pc_reg;

    localparam logic [31:0] ResetPc = 32'h0000_0000;

    logic clk;
    logic rst;

    pc_reg_if bus ();

    pc_reg #(
        .RESET_PC (ResetPc),
        .PC_STEP  (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    // Reference model state.
    logic        m_run;
    logic [31:0] m_pc;
    logic        m_pv;
    logic [31:0] m_pt;
    logic        m_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_align(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return {a[31:2], 2'b00};
`else
        return a;
`endif
    endfunction

    function automatic logic m_bad(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: drive, predict, clock, compare.
    task automatic step(input string tag, input logic r, input logic [5:0] st,
                        input logic fl, input logic [31:0] npc,
                        input logic br, input logic [31:0] tgt);
        exp_t e;
        exp_t o;
        rst                         = r;
        bus.stall                   = st;
        bus.flush                   = fl;
        bus.new_pc                  = npc;
        bus.branch_flag_i           = br;
        bus.branch_target_address_i = tgt;

        m_mis = 1'b0;
        if (r) begin
            m_run = 1'b0; m_pc = ResetPc; m_pv = 1'b0; m_pt = 32'h0;
        end else if (!m_run) begin
            m_run = 1'b1;
        end else if (fl) begin
            m_pc = m_align(npc); m_mis = m_bad(npc); m_pv = 1'b0;
        end else if (st[0]) begin
            if (br) begin
                m_pt = tgt; m_pv = 1'b1;
            end
        end else if (br) begin
            m_pc = m_align(tgt); m_mis = m_bad(tgt); m_pv = 1'b0;
        end else if (m_pv) begin
            m_pc = m_align(m_pt); m_mis = m_bad(m_pt); m_pv = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc; e.ce = m_run; e.pend = m_pv; e.mis = m_mis;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            o = sb_q.pop_front();
            check({tag, "_pc"}, bus.pc, o.pc);
            check({tag, "_ce"}, {31'd0, bus.ce}, {31'd0, o.ce});
            check({tag, "_pend"}, {31'd0, bus.branch_pending_o}, {31'd0, o.pend});
`ifdef PC_ALIGN_CHECK_EN
            check({tag, "_mis"}, {31'd0, bus.misalign_o}, {31'd0, o.mis});
`endif
        end
    endtask

    task automatic seq(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        m_run = 1'b0; m_pc = ResetPc; m_pv = 1'b0; m_pt = 32'h0; m_mis = 1'b0;

        // Reset held 3 cycles, with distracting inputs active.
        for (int i = 0; i < 3; i++) step("rst", 1'b1, 6'd1, 1'b1, 32'h500, 1'b1, 32'h600);
        check("rst_ce_const", {31'd0, bus.ce}, 32'd0);
        check("rst_pc_const", bus.pc, ResetPc);

        // Release: inputs ignored in OFF, first fetch at RESET_PC.
        step("release", 1'b0, 6'd1, 1'b1, 32'h500, 1'b1, 32'h600);
        check("release_pc_const", bus.pc, 32'h0);
        check("release_ce_const", {31'd0, bus.ce}, 32'd1);
        seq("seq", 4);  // 4, 8, C, 10
        check("seq_pc_const", bus.pc, 32'h10);

        // Branch without stall.
        step("br", 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 32'h100);
        check("br_pc_const", bus.pc, 32'h100);
        seq("br_seq", 1);  // 104

        // Branch during a 3-cycle stall.
        step("stbr", 1'b0, 6'd1, 1'b0, 32'h0, 1'b1, 32'h200);
        check("stbr_pend_const", {31'd0, bus.branch_pending_o}, 32'd1);
        step("stbr_hold", 1'b0, 6'd1, 1'b0, 32'h0, 1'b0, 32'h0);
        step("stbr_hold", 1'b0, 6'd1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stbr_hold_const", bus.pc, 32'h104);
        seq("stbr_rel", 1);
        check("stbr_rel_const", bus.pc, 32'h200);

        // Newer pending branch overwrites older.
        step("ovr1", 1'b0, 6'd1, 1'b0, 32'h0, 1'b1, 32'h300);
        step("ovr2", 1'b0, 6'd1, 1'b0, 32'h0, 1'b1, 32'h340);
        seq("ovr_rel", 1);
        check("ovr_const", bus.pc, 32'h340);

        // Live branch beats pending entry.
        step("live1", 1'b0, 6'd1, 1'b0, 32'h0, 1'b1, 32'h400);
        step("live2", 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 32'h500);
        seq("live_seq", 1);
        check("live_const", bus.pc, 32'h504);

        // Flush beats stall, branch and pending.
        step("fl_pend", 1'b0, 6'd1, 1'b0, 32'h0, 1'b1, 32'h200);
        step("fl", 1'b0, 6'd1, 1'b1, 32'h180, 1'b1, 32'h700);
        check("fl_const", bus.pc, 32'h180);
        seq("fl_seq", 1);
        check("fl_seq_const", bus.pc, 32'h184);

        // Upper stall bits are ignored.
        step("st_hi", 1'b0, 6'b111110, 1'b0, 32'h0, 1'b0, 32'h0);
        check("st_hi_const", bus.pc, 32'h188);

        // Wrap around.
        step("wrap_fl", 1'b0, 6'd0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        seq("wrap", 2);
        check("wrap_const", bus.pc, 32'h0);

        // Reset with a pending branch mid-stall.
        step("mr_pend", 1'b0, 6'd1, 1'b0, 32'h0, 1'b1, 32'h800);
        step("mr_rst", 1'b1, 6'd1, 1'b1, 32'h900, 1'b1, 32'hA00);
        check("mr_pend_const", {31'd0, bus.branch_pending_o}, 32'd0);
        step("mr_rel", 1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        seq("mr_seq", 2);
        check("mr_seq_const", bus.pc, 32'h8);

        // Misaligned branch target (corrected only when the check is enabled).
        step("mis_br", 1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 32'h102);
        seq("mis_seq", 1);
`ifdef PC_ALIGN_CHECK_EN
        check("mis_seq_const", bus.pc, 32'h104);
`else
        check("mis_seq_const", bus.pc, 32'h106);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_reg.md
Name: pc_reg

Overview:
Program counter stage directly upstream of the instruction ROM. It produces the fetch address `pc` and chip-enable `ce` that the ROM consumes each cycle. It handles pipeline stall, branch redirect, and exception flush. A branch that resolves while fetch is stalled is held in a one-entry pending-redirect buffer, so it is never lost.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.
PC_STEP, 4, sequential increment in bytes.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
stall  input  6  pipeline stall vector from ctrl; only stall[0] (fetch stall) is used here.
flush  input  1  exception/ERET flush from ctrl.
new_pc  input  32  flush target address.
branch_flag_i  input  1  branch/jump taken, from ID.
branch_target_address_i  input  32  branch target, from ID.
pc  output  32  fetch address to the instruction ROM.
ce  output  1  fetch enable to the instruction ROM.
branch_pending_o  output  1  a redirect is latched and waiting for stall release (debug/ctrl visibility).

Behaviour:
- Reset (rst=1 at posedge, any state): ce<=0, pc<=RESET_PC, pending valid<=0, pending target<=0, branch_pending_o<=0. This holds for as long as rst is high and overrides every other input, including reset arriving mid-stall or with a pending branch.
- States: OFF (ce=0) and RUN (ce=1).
  - OFF -> RUN on the first posedge with rst=0: ce<=1, pc stays RESET_PC. The first fetched address is RESET_PC, and no increment happens in that cycle.
  - In OFF, flush, stall and branch inputs are ignored.
- RUN, evaluated each posedge. Priority is flush > stall[0] > branch > pending > sequential.
  1. flush=1: pc<=new_pc, pending cleared. Applies even when stall[0]=1 or branch_flag_i=1.
  2. stall[0]=1, no flush: pc holds. If branch_flag_i=1, pending target<=branch_target_address_i and valid<=1. A newer branch overwrites an older pending one.
  3. stall[0]=0, branch_flag_i=1: pc<=branch_target_address_i and pending cleared. A live branch beats a stale pending entry.
  4. stall[0]=0, pending valid: pc<=pending target, valid<=0.
  5. Otherwise: pc<=pc+PC_STEP, as 32-bit modulo arithmetic. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Latency: a redirect (flush or branch) is visible on pc one cycle after the posedge at which it is sampled. A pending redirect is visible on the first posedge with stall[0]=0.
- branch_pending_o is registered and equals pending valid.
- stall[5:1] have no effect.
- pc and ce are registered outputs with no combinational input-to-output path.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - Adds output port `misalign_o` (1 bit, reset 0).
  - When pc is loaded from a branch, pending or flush target whose bits [1:0] != 2'b00, pc is loaded with bits [1:0] forced to 00.
  - misalign_o pulses high for exactly the cycle in which that pc value is presented.
  - Sequential increments never raise it.
- Not defined: the port is absent, and targets are loaded unmodified.

Test Plan:
- Reset release: rst=1 for 3 cycles, then 0 → ce=0 and pc=RESET_PC during reset. Cycle 1 after release: ce=1, pc=0x0. Following cycles: pc=0x4, 0x8, 0xC.
- Branch, no stall: at pc=0x10, branch_flag_i=1 with target=0x100 → next pc=0x100, then 0x104.
- Branch during stall: stall[0]=1 for 3 cycles, branch to 0x200 in the first stalled cycle → pc holds and branch_pending_o=1. First unstalled cycle: pc=0x200 and branch_pending_o=0.
- Flush priority: stall[0]=1, pending=0x200, flush=1 with new_pc=0x180 in the same cycle → pc=0x180, pending cleared. Next cycle with no stall: pc=0x184, not 0x200.
- Wrap and mid-run reset: reach pc=0xFFFF_FFFC → next pc=0x0000_0000. Assert rst with a branch pending → ce=0, pc=RESET_PC, branch_pending_o=0.
- With PC_ALIGN_CHECK_EN: branch to 0x102 → pc=0x100 and misalign_o=1 for one cycle. Next cycle: pc=0x104 and misalign_o=0.
